pc_gen: RTL and testbench

Program-counter generation stage: the first stage of the pipeline, directly upstream of instruction fetch. Owns the architectural fetch PC and drives the `dec2ifPkt` (`pc`, `pcValid`) consumed by fetch. It provides:
- a boot delay after reset,
- sequential word increment,
- redirect from later stages (branch/jump/exception),
- redirect latching while the pipeline is stalled,
- halt,
- a one-cycle squash pulse that kills wrong-path instructions already in flight.

---
 rtl/pc_gen_pkg.sv | 9 +
 rtl/pc_gen.sv | 99 +++++++++
 tb/tb_pc_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared fetch-side types and the PC generator state encoding.
package pc_gen_pkg;
  localparam int PC_WIDTH = 30;
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                pcValid;
  } dec2ifPkt;
  typedef enum logic [1:0] {BOOT, RUN, HELD, HALT} pcgenState_t;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with boot delay, increment, redirect (incl. stalled latching) and halt.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 30'h0000_0000,
  parameter int unsigned         BOOT_DELAY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                halt_i,
  output dec2ifPkt            pc2if_o,
  output logic                squash_o,
  output logic                halted_o
);
  pcgenState_t         state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pending_q, pending_d;
  logic                valid_q, valid_d, squash_q, squash_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= BOOT;
      cnt_q     <= 4'(BOOT_DELAY);
      pc_q      <= RESET_PC;
      pending_q <= '0;
      valid_q   <= 1'b0;
      squash_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      squash_q  <= squash_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    squash_d  = 1'b0;
    unique case (state_q)
      BOOT: begin
        cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = RUN;
          valid_d = 1'b1;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (stall) begin
          // Park the target so fetch issues no wrong-path reads while stalled.
          if (redirect_valid_i) begin
            pending_d = redirect_pc_i;
            state_d   = HELD;
            squash_d  = 1'b1;
            valid_d   = 1'b0;
          end
        end else if (redirect_valid_i) begin
          pc_d     = redirect_pc_i;
          squash_d = 1'b1;
        end else if (halt_i) begin
          valid_d = 1'b0;
          state_d = HALT;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      HELD: begin
        if (stall) begin
          pending_d = redirect_valid_i ? redirect_pc_i : pending_q;
          squash_d  = redirect_valid_i;
        end else begin
          pc_d     = redirect_valid_i ? redirect_pc_i : pending_q;
          squash_d = redirect_valid_i;
          valid_d  = 1'b1;
          state_d  = RUN;
        end
      end
      HALT: begin
        if (redirect_valid_i) begin
          pc_d     = redirect_pc_i;
          valid_d  = 1'b1;
          squash_d = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end
  assign pc2if_o  = '{pc: pc_q, pcValid: valid_q};
  assign squash_o = squash_q;
  assign halted_o = (state_q == HALT);
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of boot, wrap, stalled redirect, halt and reset behaviour.
module tb_pc_gen;
  import pc_gen_pkg::*;
  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                stall = 1'b0;
  logic                redirect_valid_i = 1'b0;
  logic [PC_WIDTH-1:0] redirect_pc_i = '0;
  logic                halt_i = 1'b0;
  dec2ifPkt            pc2if_o;
  logic                squash_o, halted_o;
  int                  n_checks = 0, n_fail = 0;

  pc_gen #(.RESET_PC(30'h100), .BOOT_DELAY(2)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .pc2if_o(pc2if_o), .squash_o(squash_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [PC_WIDTH-1:0] t);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = t;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", pc2if_o.pcValid); end
    n_checks++; if (squash_o !== 1'b0) begin n_fail++; $display("FAIL reset_squash got %b exp 0", squash_o); end
    n_checks++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted_o); end
    n_checks++; if (pc2if_o.pc !== 30'h100) begin n_fail++; $display("FAIL reset_pc got %h exp 100", pc2if_o.pc); end
  endtask

  task automatic test_boot();
    logic [PC_WIDTH-1:0] exp_pc [3] = '{30'h100, 30'h101, 30'h102};
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (pc2if_o.pcValid !== 1'b0) begin n_fail++; $display("FAIL boot_wait%0d valid got %b exp 0", i, pc2if_o.pcValid); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== exp_pc[i])
        begin n_fail++; $display("FAIL boot_run%0d got v=%b pc=%h exp v=1 pc=%h", i, pc2if_o.pcValid, pc2if_o.pc, exp_pc[i]); end
      n_checks++; if (squash_o !== 1'b0) begin n_fail++; $display("FAIL boot_squash%0d got %b exp 0", i, squash_o); end
    end
  endtask

  task automatic test_wrap();
    logic [PC_WIDTH-1:0] exp_pc [4] = '{30'h3ffffffe, 30'h3fffffff, 30'h0, 30'h1};
    int sq = 0;
    redir(30'h3ffffffe);
    for (int i = 0; i < 4; i++) begin
      step();
      redirect_valid_i = 1'b0;
      sq += int'(squash_o);
      n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== exp_pc[i])
        begin n_fail++; $display("FAIL wrap%0d got v=%b pc=%h exp v=1 pc=%h", i, pc2if_o.pcValid, pc2if_o.pc, exp_pc[i]); end
    end
    n_checks++; if (sq != 1) begin n_fail++; $display("FAIL wrap_squash_count got %0d exp 1", sq); end
  endtask

  task automatic test_stalled_redirect();
    stall = 1'b1;
    redir(30'h40);
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0 || squash_o !== 1'b1 || pc2if_o.pc !== 30'h1)
      begin n_fail++; $display("FAIL stall1 got v=%b sq=%b pc=%h exp v=0 sq=1 pc=1", pc2if_o.pcValid, squash_o, pc2if_o.pc); end
    redir(30'h80);
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0 || squash_o !== 1'b1)
      begin n_fail++; $display("FAIL stall2 got v=%b sq=%b exp v=0 sq=1", pc2if_o.pcValid, squash_o); end
    redirect_valid_i = 1'b0;
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0 || squash_o !== 1'b0)
      begin n_fail++; $display("FAIL stall3 got v=%b sq=%b exp v=0 sq=0", pc2if_o.pcValid, squash_o); end
    stall = 1'b0;
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== 30'h80 || squash_o !== 1'b0)
      begin n_fail++; $display("FAIL stall_release got v=%b pc=%h sq=%b exp v=1 pc=80 sq=0", pc2if_o.pcValid, pc2if_o.pc, squash_o); end
  endtask

  task automatic test_collision();
    stall = 1'b1;
    redir(30'h40);
    step();
    stall = 1'b0;
    redir(30'h90);
    step();
    redirect_valid_i = 1'b0;
    n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== 30'h90 || squash_o !== 1'b1)
      begin n_fail++; $display("FAIL collision got v=%b pc=%h sq=%b exp v=1 pc=90 sq=1", pc2if_o.pcValid, pc2if_o.pc, squash_o); end
    step();
    n_checks++; if (pc2if_o.pc !== 30'h91) begin n_fail++; $display("FAIL collision_next got %h exp 91", pc2if_o.pc); end
  endtask

  task automatic test_halt();
    redir(30'h10);
    step();
    redirect_valid_i = 1'b0;
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    n_checks++; if (pc2if_o.pcValid !== 1'b0 || halted_o !== 1'b1 || pc2if_o.pc !== 30'h10)
      begin n_fail++; $display("FAIL halt got v=%b h=%b pc=%h exp v=0 h=1 pc=10", pc2if_o.pcValid, halted_o, pc2if_o.pc); end
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0 || halted_o !== 1'b1)
      begin n_fail++; $display("FAIL halt_hold got v=%b h=%b exp v=0 h=1", pc2if_o.pcValid, halted_o); end
    stall = 1'b1;
    redir(30'h200);
    step();
    stall = 1'b0;
    n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== 30'h200 || squash_o !== 1'b1 || halted_o !== 1'b0)
      begin n_fail++; $display("FAIL resume got v=%b pc=%h sq=%b h=%b exp v=1 pc=200 sq=1 h=0", pc2if_o.pcValid, pc2if_o.pc, squash_o, halted_o); end
    redir(30'h300);
    halt_i = 1'b1;
    step();
    redirect_valid_i = 1'b0;
    halt_i = 1'b0;
    n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== 30'h300 || halted_o !== 1'b0)
      begin n_fail++; $display("FAIL redir_beats_halt got v=%b pc=%h h=%b exp v=1 pc=300 h=0", pc2if_o.pcValid, pc2if_o.pc, halted_o); end
    step();
    n_checks++; if (pc2if_o.pc !== 30'h301 || halted_o !== 1'b0)
      begin n_fail++; $display("FAIL after_redir_halt got pc=%h h=%b exp pc=301 h=0", pc2if_o.pc, halted_o); end
  endtask

  task automatic test_reset_mid_held();
    stall = 1'b1;
    redir(30'h40);
    step();
    redirect_valid_i = 1'b0;
    rst = 1'b0;
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0 || squash_o !== 1'b0 || pc2if_o.pc !== 30'h100)
      begin n_fail++; $display("FAIL mid_reset got v=%b sq=%b pc=%h exp v=0 sq=0 pc=100", pc2if_o.pcValid, squash_o, pc2if_o.pc); end
    rst = 1'b1;
    stall = 1'b0;
    step();
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_boot got v=%b exp 0", pc2if_o.pcValid); end
    step();
    n_checks++; if (pc2if_o.pcValid !== 1'b1 || pc2if_o.pc !== 30'h100)
      begin n_fail++; $display("FAIL mid_reset_first got v=%b pc=%h exp v=1 pc=100", pc2if_o.pcValid, pc2if_o.pc); end
    step();
    n_checks++; if (pc2if_o.pc !== 30'h101) begin n_fail++; $display("FAIL mid_reset_next got %h exp 101", pc2if_o.pc); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_wrap();
    test_stalled_redirect();
    test_collision();
    test_halt();
    test_reset_mid_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
